// File: rtl/neander_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neander_pkg
//  Description : Shared opcodes, FSM state encoding, ALU operation enum and
//                decode helpers for the neander_core accumulator processor.
//                Build option: NEANDER_SUB_EN enables opcode 0x7 (SUB a).
//  Revision    : 1.0 - initial release
// ============================================================================
package neander_pkg;

    // Opcode field values (top four bits of an instruction word)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Controller states; the numeric values are visible on state_o
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPND   = 3'd3,
        ST_EXEC   = 3'd4
    } state_e;

    // ALU operations
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_OR   = 3'd2,
        ALU_AND  = 3'd3,
        ALU_NOT  = 3'd4,
        ALU_SUB  = 3'd5
    } alu_op_e;

    // Two-word instructions that change the PC in OPND
    function automatic logic is_jump(input logic [3:0] opc);
        return (opc == OP_JMP) || (opc == OP_JN) || (opc == OP_JZ);
    endfunction

    // Two-word instructions that access data memory in EXEC
    function automatic logic is_mem_op(input logic [3:0] opc);
        logic r;
        r = (opc == OP_STA) || (opc == OP_LDA) || (opc == OP_ADD) ||
            (opc == OP_OR)  || (opc == OP_AND);
`ifdef NEANDER_SUB_EN
        r = r || (opc == OP_SUB);
`endif
        return r;
    endfunction

    // ALU operation applied in EXEC for a memory-operand instruction
    function automatic alu_op_e alu_op_for(input logic [3:0] opc);
        alu_op_e r;
        case (opc)
            OP_ADD:  r = ALU_ADD;
            OP_OR:   r = ALU_OR;
            OP_AND:  r = ALU_AND;
`ifdef NEANDER_SUB_EN
            OP_SUB:  r = ALU_SUB;
`endif
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

endpackage : neander_pkg
`default_nettype wire

// File: rtl/neander_alu.sv
`default_nettype none
// ============================================================================
//  Module      : neander_alu
//  Description : Combinational accumulator ALU: pass, add, or, and, not and,
//                when NEANDER_SUB_EN is defined, subtract. Arithmetic wraps
//                modulo 2^DATA_W; carries and borrows are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module neander_alu
    import neander_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e             op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [DATA_W-1:0]   y_o
);

    // Result select; a is the accumulator, b the memory operand
    always_comb begin
        y_o = b_i;
        case (op_i)
            ALU_PASS: y_o = b_i;
            ALU_ADD:  y_o = a_i + b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_NOT:  y_o = ~a_i;
`ifdef NEANDER_SUB_EN
            ALU_SUB:  y_o = a_i - b_i;
`endif
            default:  y_o = b_i;
        endcase
    end

endmodule : neander_alu
`default_nettype wire

// File: rtl/neander_core.sv
`default_nettype none
// ============================================================================
//  Module      : neander_core
//  Description : Neander-class accumulator processor running from an external
//                single-port memory with same-cycle reads. Holds the FSM, PC,
//                REM, IR, AC and N/Z flags; arithmetic lives in neander_alu.
//                Build option: NEANDER_SUB_EN adds opcode 0x7 (SUB a).
//  Revision    : 1.0 - initial release
// ============================================================================
module neander_core
    import neander_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] ac_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [1:0]        flags_o,
    output logic [2:0]        state_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;
    logic [ADDR_W-1:0]   rem_q,   rem_d;
    logic [3:0]          ir_q,    ir_d;
    logic [DATA_W-1:0]   ac_q,    ac_d;
    logic                n_q,     n_d;
    logic                z_q,     z_d;

    logic                ac_wr;
    alu_op_e             alu_op;
    logic [DATA_W-1:0]   alu_y;
    logic [ADDR_W-1:0]   operand;
    logic [ADDR_W-1:0]   pc_inc;
    logic                jump_taken;

    assign operand = mem_rdata[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);

    neander_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i (alu_op),
        .a_i  (ac_q),
        .b_i  (mem_rdata),
        .y_o  (alu_y)
    );

    // Branch condition for the jump currently held in IR
    always_comb begin
        jump_taken = 1'b0;
        case (ir_q)
            OP_JMP:  jump_taken = 1'b1;
            OP_JN:   jump_taken = n_q;
            OP_JZ:   jump_taken = z_q;
            default: jump_taken = 1'b0;
        endcase
    end

    // Next-state, register updates and memory interface control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rem_d    = rem_q;
        ir_d     = ir_q;
        ac_wr    = 1'b0;
        alu_op   = ALU_PASS;
        mem_addr = pc_q;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = mem_rdata[DATA_W-1 -: 4];
                pc_d    = pc_inc;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (ir_q == OP_NOP) begin
                    state_d = ST_FETCH;
                end else if (ir_q == OP_NOT) begin
                    alu_op  = ALU_NOT;
                    ac_wr   = 1'b1;
                    state_d = ST_FETCH;
                end else if (is_jump(ir_q) || is_mem_op(ir_q)) begin
                    state_d = ST_OPND;
                end else begin
                    // HLT and every undefined opcode stop here
                    state_d = ST_IDLE;
                end
            end
            ST_OPND: begin
                state_d = ST_FETCH;
                if (is_jump(ir_q)) begin
                    pc_d = jump_taken ? operand : pc_inc;
                end else begin
                    rem_d   = operand;
                    pc_d    = pc_inc;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                mem_addr = rem_q;
                if (ir_q == OP_STA) begin
                    mem_we = 1'b1;
                end else begin
                    alu_op = alu_op_for(ir_q);
                    ac_wr  = 1'b1;
                end
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator and flags change together, only on an AC write
    always_comb begin
        ac_d = ac_q;
        n_d  = n_q;
        z_d  = z_q;
        if (ac_wr) begin
            ac_d = alu_y;
            n_d  = alu_y[DATA_W-1];
            z_d  = (alu_y == '0);
        end
    end

    // Architectural state registers; reset abandons any partial instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            ir_q    <= '0;
            ac_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign halted    = (state_q == ST_IDLE);
    assign mem_wdata = ac_q;
    assign ac_o      = ac_q;
    assign pc_o      = pc_q;
    assign flags_o   = {n_q, z_q};
    assign state_o   = state_q;

endmodule : neander_core
`default_nettype wire

// File: tb/tb_neander_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neander_core
//  Description : Directed self-checking bench for neander_core with a
//                behavioural single-port memory (combinational read,
//                write on the clock edge). With NEANDER_SUB_EN defined a
//                second 12-bit instance exercises SUB.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neander_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       halted;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] ac_o;
    logic [7:0] pc_o;
    logic [1:0] flags_o;
    logic [2:0] state_o;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    neander_core #(
        .DATA_W (8),
        .ADDR_W (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halted    (halted),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .ac_o      (ac_o),
        .pc_o      (pc_o),
        .flags_o   (flags_o),
        .state_o   (state_o)
    );

    assign mem_rdata = mem[mem_addr];

    // Memory write port
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

`ifdef NEANDER_SUB_EN
    logic        start12 = 1'b0;
    logic        halted12;
    logic [7:0]  mem_addr12;
    logic [11:0] mem_rdata12;
    logic [11:0] mem_wdata12;
    logic        mem_we12;
    logic [11:0] ac12;
    logic [7:0]  pc12;
    logic [1:0]  flags12;
    logic [2:0]  state12;
    logic [11:0] mem12 [256];

    neander_core #(
        .DATA_W (12),
        .ADDR_W (8)
    ) u_dut12 (
        .clk       (clk),
        .rst       (rst),
        .start     (start12),
        .halted    (halted12),
        .mem_addr  (mem_addr12),
        .mem_rdata (mem_rdata12),
        .mem_wdata (mem_wdata12),
        .mem_we    (mem_we12),
        .ac_o      (ac12),
        .pc_o      (pc12),
        .flags_o   (flags12),
        .state_o   (state12)
    );

    assign mem_rdata12 = mem12[mem_addr12];

    always @(posedge clk) begin
        if (mem_we12) mem12[mem_addr12] = mem_wdata12;
    end
`endif

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Pulse start for one cycle, then count cycles from FETCH entry until halted
    task automatic run(input int max_cyc, output int cyc, output logic [2:0] st0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        st0 = state_o;
        cyc = 0;
        while (!halted && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        n_tests++; if (halted !== 1'b1)    begin n_fail++; $display("FAIL reset_halted: got %b want 1", halted); end
        n_tests++; if (state_o !== 3'd0)   begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_tests++; if (pc_o !== 8'h00)     begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc_o); end
        n_tests++; if (ac_o !== 8'h00)     begin n_fail++; $display("FAIL reset_ac: got %h want 00", ac_o); end
        n_tests++; if (flags_o !== 2'b01)  begin n_fail++; $display("FAIL reset_flags: got %b want 01", flags_o); end
        n_tests++; if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_tests++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    endtask

    task automatic test_add_store();
        int cyc;
        logic [2:0] st0;
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h30; mem[3] = 8'h81;
        mem[4] = 8'h10; mem[5] = 8'h82; mem[6] = 8'hF0;
        mem[8'h80] = 8'h07; mem[8'h81] = 8'h07;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (st0 !== 3'd1)        begin n_fail++; $display("FAIL add_fetch_after_start: got %0d want 1", st0); end
        n_tests++; if (cyc !== 14)          begin n_fail++; $display("FAIL add_cycles: got %0d want 14", cyc); end
        n_tests++; if (mem[8'h82] !== 8'h0E) begin n_fail++; $display("FAIL add_store: got %h want 0e", mem[8'h82]); end
        n_tests++; if (ac_o !== 8'h0E)      begin n_fail++; $display("FAIL add_ac: got %h want 0e", ac_o); end
        n_tests++; if (flags_o !== 2'b00)   begin n_fail++; $display("FAIL add_flags: got %b want 00", flags_o); end
        n_tests++; if (pc_o !== 8'h07)      begin n_fail++; $display("FAIL add_pc: got %h want 07", pc_o); end
    endtask

    task automatic test_jump_zero();
        int cyc;
        logic [2:0] st0;
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'hA0; mem[3] = 8'h10;
        mem[4] = 8'hF0; mem[8'h10] = 8'hF0; mem[8'h40] = 8'h00;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (pc_o !== 8'h11)     begin n_fail++; $display("FAIL jz_taken_pc: got %h want 11", pc_o); end
        n_tests++; if (flags_o !== 2'b01)  begin n_fail++; $display("FAIL jz_taken_flags: got %b want 01", flags_o); end
        n_tests++; if (cyc !== 9)          begin n_fail++; $display("FAIL jz_taken_cycles: got %0d want 9", cyc); end
        mem[8'h40] = 8'h01;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (pc_o !== 8'h05)     begin n_fail++; $display("FAIL jz_fall_pc: got %h want 05", pc_o); end
        n_tests++; if (flags_o !== 2'b00)  begin n_fail++; $display("FAIL jz_fall_flags: got %b want 00", flags_o); end
        n_tests++; if (cyc !== 9)          begin n_fail++; $display("FAIL jz_fall_cycles: got %0d want 9", cyc); end
    endtask

    task automatic test_neg_not_wrap();
        int cyc;
        logic [2:0] st0;
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'h60; mem[3] = 8'h90;
        mem[4] = 8'h20; mem[5] = 8'hF0; mem[8'h20] = 8'hF0; mem[8'h40] = 8'h7F;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (ac_o !== 8'h80)     begin n_fail++; $display("FAIL not_ac: got %h want 80", ac_o); end
        n_tests++; if (flags_o !== 2'b10)  begin n_fail++; $display("FAIL not_flags: got %b want 10", flags_o); end
        n_tests++; if (pc_o !== 8'h21)     begin n_fail++; $display("FAIL jn_pc: got %h want 21", pc_o); end
        n_tests++; if (cyc !== 11)         begin n_fail++; $display("FAIL jn_cycles: got %0d want 11", cyc); end
        // JMP FE; NOP at FE; JMP at FF whose operand wraps to address 00 (0x80)
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h80;
        mem[8'h80] = 8'hF0;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (pc_o !== 8'h81)     begin n_fail++; $display("FAIL wrap_pc: got %h want 81", pc_o); end
        n_tests++; if (cyc !== 10)         begin n_fail++; $display("FAIL wrap_cycles: got %0d want 10", cyc); end
    endtask

    task automatic test_reset_mid_op();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'h10; mem[3] = 8'h41;
        mem[4] = 8'hF0; mem[8'h40] = 8'h55;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_tests++; if (state_o !== 3'd4)   begin n_fail++; $display("FAIL mid_state_exec: got %0d want 4", state_o); end
        n_tests++; if (mem_we !== 1'b1)    begin n_fail++; $display("FAIL mid_we_before: got %b want 1", mem_we); end
        rst = 1'b0;
        #1;
        n_tests++; if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL mid_we_after: got %b want 0", mem_we); end
        n_tests++; if (halted !== 1'b1)    begin n_fail++; $display("FAIL mid_halted: got %b want 1", halted); end
        n_tests++; if (state_o !== 3'd0)   begin n_fail++; $display("FAIL mid_state: got %0d want 0", state_o); end
        n_tests++; if (ac_o !== 8'h00)     begin n_fail++; $display("FAIL mid_ac: got %h want 00", ac_o); end
        n_tests++; if (pc_o !== 8'h00)     begin n_fail++; $display("FAIL mid_pc: got %h want 00", pc_o); end
        n_tests++; if (flags_o !== 2'b01)  begin n_fail++; $display("FAIL mid_flags: got %b want 01", flags_o); end
        n_tests++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_addr: got %h want 00", mem_addr); end
        @(negedge clk);
        n_tests++; if (mem[8'h41] !== 8'h00) begin n_fail++; $display("FAIL mid_no_write: got %h want 00", mem[8'h41]); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_undef_start();
        int cyc;
        logic [2:0] st0;
        clear_mem();
        mem[0] = 8'hB0;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (cyc !== 2)          begin n_fail++; $display("FAIL undef_cycles: got %0d want 2", cyc); end
        n_tests++; if (pc_o !== 8'h01)     begin n_fail++; $display("FAIL undef_pc: got %h want 01", pc_o); end
        // start pulsed mid-program must not disturb execution
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'h30; mem[3] = 8'h40;
        mem[4] = 8'hF0; mem[8'h40] = 8'h03;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 3);
        end
        start = 1'b0;
        n_tests++; if (cyc !== 10)         begin n_fail++; $display("FAIL ignstart_cycles: got %0d want 10", cyc); end
        n_tests++; if (ac_o !== 8'h06)     begin n_fail++; $display("FAIL ignstart_ac: got %h want 06", ac_o); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_st [6];
        exp_st[0] = 3'd1; exp_st[1] = 3'd2; exp_st[2] = 3'd0;
        exp_st[3] = 3'd1; exp_st[4] = 3'd2; exp_st[5] = 3'd0;
        clear_mem();
        mem[0] = 8'hF0; mem[1] = 8'hF0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++; if (state_o !== exp_st[i]) begin n_fail++; $display("FAIL held_start_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]); end
        end
        n_tests++; if (pc_o !== 8'h02)     begin n_fail++; $display("FAIL held_start_pc: got %h want 02", pc_o); end
        start = 1'b0;
    endtask

    task automatic test_sub();
        int cyc;
`ifdef NEANDER_SUB_EN
        for (int i = 0; i < 256; i++) mem12[i] = 12'h000;
        mem12[0] = 12'h200; mem12[1] = 12'h040; mem12[2] = 12'h700; mem12[3] = 12'h041;
        mem12[4] = 12'hF00; mem12[8'h40] = 12'h005; mem12[8'h41] = 12'h007;
        do_reset();
        @(negedge clk);
        start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        cyc = 0;
        while (!halted12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (ac12 !== 12'hFFE)   begin n_fail++; $display("FAIL sub_ac: got %h want ffe", ac12); end
        n_tests++; if (flags12 !== 2'b10)  begin n_fail++; $display("FAIL sub_flags: got %b want 10", flags12); end
        n_tests++; if (cyc !== 10)         begin n_fail++; $display("FAIL sub_cycles: got %0d want 10", cyc); end
`else
        logic [2:0] st0;
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'h70; mem[3] = 8'h41;
        mem[4] = 8'hF0; mem[8'h40] = 8'h05; mem[8'h41] = 8'h07;
        do_reset();
        run(200, cyc, st0);
        n_tests++; if (cyc !== 6)          begin n_fail++; $display("FAIL op7_halt_cycles: got %0d want 6", cyc); end
        n_tests++; if (pc_o !== 8'h03)     begin n_fail++; $display("FAIL op7_halt_pc: got %h want 03", pc_o); end
        n_tests++; if (ac_o !== 8'h05)     begin n_fail++; $display("FAIL op7_halt_ac: got %h want 05", ac_o); end
`endif
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        test_reset();
        test_add_store();
        test_jump_zero();
        test_neg_not_wrap();
        test_reset_mid_op();
        test_undef_start();
        test_back_to_back();
        test_sub();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_neander_core
`default_nettype wire
